// File: rtl/sp_ram_arb_pkg.sv
// Shared types and constants for the single-port RAM arbiter.
package sp_ram_arb_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam logic RAM_WR = 1'b1;
    localparam logic RAM_RD = 1'b0;

    // Width of a requester index; never zero so a single-port build still has a port.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the requester at ptr has top priority,
// then ptr+1, ptr+2, ... wrapping modulo N.
module rr_arbiter
    import sp_ram_arb_pkg::*;
#(
    parameter int N  = 2,
    parameter int IW = idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] win,
    output logic          any
);

    // Scan from the pointer; the first active request found wins.
    always_comb begin
        int k;
        k   = 0;
        gnt = '0;
        win = '0;
        any = 1'b0;
        for (int off = 0; off < N; off++) begin
            k = (int'(ptr) + off) % N;
            if (!any && req[k]) begin
                any    = 1'b1;
                gnt[k] = 1'b1;
                win    = IW'(k);
            end
        end
    end

endmodule

// File: rtl/sp_ram_arbiter.sv
// Round-robin arbiter sharing one single-port RAM macro between NUM_REQ
// requesters, one access per cycle, with read-valid aligned to the macro's
// 1-cycle read latency.
// Build option: define SP_RAM_ARBITER_INIT_EN to add a post-reset sweep that
// zero-fills every RAM word before requests are accepted.
module sp_ram_arbiter
    import sp_ram_arb_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                          CLK,
    input  logic                          RSTN,
    input  logic [NUM_REQ-1:0]            REQ,
    input  logic [NUM_REQ-1:0]            WE,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] ADDR,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] WDATA,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] WMASK,
    output logic [NUM_REQ-1:0]            GNT,
    output logic [NUM_REQ-1:0]            RVALID,
    output logic [DATA_WIDTH-1:0]         RDATA,
    output logic                          INIT_DONE,
    output logic [ADDR_WIDTH-1:0]         RAM_A,
    output logic [DATA_WIDTH-1:0]         RAM_DI,
    output logic [DATA_WIDTH-1:0]         RAM_BW,
    output logic                          RAM_CE,
    output logic                          RAM_RDWEN,
    input  logic [DATA_WIDTH-1:0]         RAM_DO
);

    localparam int IW    = idx_w(NUM_REQ);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [IW-1:0]         ptr;
    logic [IW-1:0]         win;
    logic [NUM_REQ-1:0]    gnt;
    logic                  any;
    logic                  run;
    logic                  init_act;
    logic [ADDR_WIDTH-1:0] init_addr;

`ifdef SP_RAM_ARBITER_INIT_EN
    state_e                state;
    logic [ADDR_WIDTH:0]   cnt;
    logic                  init_done_q;

    // Zero-fill sweep: one word per cycle, then hand the RAM to the requesters.
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state       <= ST_INIT;
            cnt         <= '0;
            init_done_q <= 1'b0;
        end else if (state == ST_INIT) begin
            cnt <= cnt + 1'b1;
            if (cnt == (ADDR_WIDTH+1)'(DEPTH - 1)) begin
                state       <= ST_RUN;
                init_done_q <= 1'b1;
            end
        end
    end

    assign INIT_DONE = init_done_q;
    assign init_act  = RSTN && (state == ST_INIT);
    assign init_addr = cnt[ADDR_WIDTH-1:0];
`else
    assign INIT_DONE = 1'b1;
    assign init_act  = 1'b0;
    assign init_addr = '0;
`endif

    // Gating on RSTN keeps the macro idle in every reset cycle.
    assign run = RSTN && INIT_DONE;

    rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_arb (
        .req (REQ & {NUM_REQ{run}}),
        .ptr (ptr),
        .gnt (gnt),
        .win (win),
        .any (any)
    );

    assign GNT   = gnt;
    assign RDATA = RAM_DO;

    // Priority moves to the port after the one just served.
    always_ff @(posedge CLK) begin
        if (!RSTN)
            ptr <= '0;
        else if (any)
            ptr <= (win == IW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
    end

    // Read-valid follows a granted read by exactly one cycle; reset drops it.
    always_ff @(posedge CLK) begin
        if (!RSTN)
            RVALID <= '0;
        else
            RVALID <= gnt & ~WE;
    end

    // Steer the winning port (or the init sweep) onto the macro pins.
    always_comb begin
        RAM_CE    = any;
        RAM_A     = '0;
        RAM_DI    = '0;
        RAM_BW    = '0;
        RAM_RDWEN = RAM_RD;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                RAM_A     = ADDR[i*ADDR_WIDTH +: ADDR_WIDTH];
                RAM_DI    = WDATA[i*DATA_WIDTH +: DATA_WIDTH];
                RAM_BW    = WMASK[i*DATA_WIDTH +: DATA_WIDTH];
                RAM_RDWEN = WE[i];
            end
        end
        if (init_act) begin
            RAM_CE    = 1'b1;
            RAM_A     = init_addr;
            RAM_DI    = '0;
            RAM_BW    = '1;
            RAM_RDWEN = RAM_WR;
        end
    end

endmodule

// File: tb/tb_sp_ram_arbiter.sv
// Self-checking bench for sp_ram_arbiter (2 ports, 16 x 32 RAM).
module tb_sp_ram_arbiter;

    localparam int N     = 2;
    localparam int AW    = 4;
    localparam int DW    = 32;
    localparam int DEPTH = 16;

    logic            CLK = 1'b0;
    logic            RSTN;
    logic [N-1:0]    REQ, WE, GNT, RVALID;
    logic [N*AW-1:0] ADDR;
    logic [N*DW-1:0] WDATA, WMASK;
    logic [DW-1:0]   RDATA, RAM_DI, RAM_BW, RAM_DO;
    logic [AW-1:0]   RAM_A;
    logic            INIT_DONE, RAM_CE, RAM_RDWEN;

    int checks   = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    sp_ram_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .CLK(CLK), .RSTN(RSTN), .REQ(REQ), .WE(WE), .ADDR(ADDR), .WDATA(WDATA),
        .WMASK(WMASK), .GNT(GNT), .RVALID(RVALID), .RDATA(RDATA),
        .INIT_DONE(INIT_DONE), .RAM_A(RAM_A), .RAM_DI(RAM_DI), .RAM_BW(RAM_BW),
        .RAM_CE(RAM_CE), .RAM_RDWEN(RAM_RDWEN), .RAM_DO(RAM_DO)
    );

    // Behavioural single-port macro, 1-cycle read latency.
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] ram_do = '0;
    assign RAM_DO = ram_do;
    always @(posedge CLK) begin
        if (RAM_CE) begin
            if (RAM_RDWEN) mem[RAM_A] <= (mem[RAM_A] & ~RAM_BW) | (RAM_DI & RAM_BW);
            else           ram_do <= mem[RAM_A];
        end
    end

    // Reference model: expected memory contents, rotating priority, pending reads.
    logic [DW-1:0] sh [DEPTH];
    int            mptr;
    bit            model_run;
    logic [N-1:0]  exp_gnt, exp_rv, nxt_rv;
    logic [DW-1:0] exp_rd, nxt_rd;

    task automatic drive(input logic [1:0] req, input logic [1:0] we,
                         input logic [3:0] a0, input logic [3:0] a1,
                         input logic [31:0] d0, input logic [31:0] d1,
                         input logic [31:0] m0, input logic [31:0] m1);
        REQ = req; WE = we; ADDR = {a1, a0}; WDATA = {d1, d0}; WMASK = {m1, m0};
    endtask

    task automatic model_eval();
        logic [AW-1:0] a;
        logic [DW-1:0] d, m;
        int k;
        bit found;
        exp_gnt = '0;
        found = 0;
        if (RSTN && model_run) begin
            for (int off = 0; off < N; off++) begin
                k = (mptr + off) % N;
                if (!found && REQ[k]) begin
                    found = 1;
                    exp_gnt[k] = 1'b1;
                    a = ADDR[k*AW +: AW];
                    d = WDATA[k*DW +: DW];
                    m = WMASK[k*DW +: DW];
                    if (WE[k]) sh[a] = (sh[a] & ~m) | (d & m);
                    else begin nxt_rv[k] = 1'b1; nxt_rd = sh[a]; end
                    mptr = (k + 1) % N;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
        exp_rv = nxt_rv;
        exp_rd = nxt_rd;
        nxt_rv = '0;
    endtask

    task automatic model_reset();
        mptr = 0; exp_rv = '0; nxt_rv = '0;
`ifdef SP_RAM_ARBITER_INIT_EN
        model_run = 0;
`else
        model_run = 1;
`endif
    endtask

    task automatic test_reset();
        RSTN = 1'b0;
        drive(2'b11, 2'b00, 4'd1, 4'd2, 0, 0, 0, 0);
        tick();
        model_reset();
        #3;
        checks++;
        if (GNT !== 2'b00 || RAM_CE !== 1'b0 || RVALID !== 2'b00) begin
            failures++;
            $display("FAIL reset_outputs: gnt=%b ce=%b rvalid=%b want gnt=00 ce=0 rvalid=00", GNT, RAM_CE, RVALID);
        end
        checks++;
        if (INIT_DONE !== logic'(model_run)) begin
            failures++;
            $display("FAIL reset_init_done: got %b want %b", INIT_DONE, model_run);
        end
        tick();
        drive(2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_init();
        RSTN = 1'b1;
`ifdef SP_RAM_ARBITER_INIT_EN
        drive(2'b11, 2'b00, 4'd0, 4'd0, 0, 0, 0, 0);
        for (int i = 0; i < DEPTH; i++) begin
            #3;
            checks++;
            if (RAM_CE !== 1'b1 || RAM_A !== 4'(i) || RAM_RDWEN !== 1'b1 ||
                RAM_BW !== 32'hFFFF_FFFF || RAM_DI !== 32'h0 || GNT !== 2'b00 || INIT_DONE !== 1'b0) begin
                failures++;
                $display("FAIL init_sweep[%0d]: ce=%b a=%0d wr=%b bw=%h di=%h gnt=%b done=%b want ce=1 a=%0d wr=1 bw=ffffffff di=0 gnt=00 done=0",
                         i, RAM_CE, RAM_A, RAM_RDWEN, RAM_BW, RAM_DI, GNT, INIT_DONE, i);
            end
            if (i == DEPTH - 1) drive(2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
            tick();
        end
        model_run = 1;
        for (int i = 0; i < DEPTH; i++) sh[i] = '0;
        #3;
        checks++;
        if (INIT_DONE !== 1'b1) begin
            failures++;
            $display("FAIL init_done_at_16: got %b want 1", INIT_DONE);
        end
        tick();
`else
        // Without the sweep, fill the RAM with zeros through port 0.
        for (int i = 0; i < DEPTH; i++) begin
            drive(2'b01, 2'b01, 4'(i), 4'd0, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'h0);
            #3;
            model_eval();
            checks++;
            if (GNT !== exp_gnt || INIT_DONE !== 1'b1) begin
                failures++;
                $display("FAIL zero_fill[%0d]: gnt=%b done=%b want gnt=%b done=1", i, GNT, INIT_DONE, exp_gnt);
            end
            tick();
        end
`endif
        drive(2'b01, 2'b00, 4'd7, 4'd0, 0, 0, 0, 0);
        #3;
        model_eval();
        tick();
        drive(2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
        #3;
        checks++;
        if (RVALID !== 2'b01 || RDATA !== 32'h0) begin
            failures++;
            $display("FAIL init_read7: rvalid=%b rdata=%h want rvalid=01 rdata=00000000", RVALID, RDATA);
        end
        tick();
    endtask

    task automatic test_contention();
        logic [31:0] d3, d5;
        d3 = $urandom; d5 = $urandom;
        drive(2'b01, 2'b01, 4'd3, 4'd0, d3, 0, 32'hFFFF_FFFF, 0);
        #3; model_eval(); tick();
        drive(2'b10, 2'b10, 4'd0, 4'd5, 0, d5, 0, 32'hFFFF_FFFF);
        #3; model_eval(); tick();
        drive(2'b11, 2'b00, 4'd3, 4'd5, 0, 0, 0, 0);
        #3; model_eval();
        checks++;
        if (GNT !== 2'b01) begin failures++; $display("FAIL contention_gnt0: got %b want 01", GNT); end
        tick();
        drive(2'b10, 2'b00, 4'd3, 4'd5, 0, 0, 0, 0);
        #3;
        checks++;
        if (RVALID !== 2'b01 || RDATA !== d3) begin
            failures++;
            $display("FAIL contention_rv0: rvalid=%b rdata=%h want 01 %h", RVALID, RDATA, d3);
        end
        model_eval();
        checks++;
        if (GNT !== 2'b10) begin failures++; $display("FAIL contention_gnt1: got %b want 10", GNT); end
        tick();
        drive(2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
        #3;
        checks++;
        if (RVALID !== 2'b10 || RDATA !== d5) begin
            failures++;
            $display("FAIL contention_rv1: rvalid=%b rdata=%h want 10 %h", RVALID, RDATA, d5);
        end
        model_eval(); tick();
    endtask

    task automatic test_fairness();
        int c0, c1;
        c0 = 0; c1 = 0;
        for (int i = 0; i <= 8; i++) begin
            if (i < 8) drive(2'b11, 2'b00, 4'($urandom), 4'($urandom), 0, 0, 0, 0);
            else       drive(2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
            #3;
            checks++;
            if (RVALID !== exp_rv || (exp_rv != 0 && RDATA !== exp_rd)) begin
                failures++;
                $display("FAIL fair_rdata[%0d]: rvalid=%b rdata=%h want %b %h", i, RVALID, RDATA, exp_rv, exp_rd);
            end
            model_eval();
            if (i < 8) begin
                checks++;
                if (GNT !== exp_gnt) begin
                    failures++;
                    $display("FAIL fair_gnt[%0d]: got %b want %b", i, GNT, exp_gnt);
                end
                c0 += int'(GNT[0]); c1 += int'(GNT[1]);
            end
            tick();
        end
        checks++;
        if (c0 != 4 || c1 != 4) begin
            failures++;
            $display("FAIL fair_counts: port0=%0d port1=%0d want 4 4", c0, c1);
        end
    endtask

    task automatic test_masked_write();
        drive(2'b01, 2'b01, 4'd2, 0, 32'hFFFF_FFFF, 0, 32'hFFFF_FFFF, 0);
        #3; model_eval();
        checks++;
        if (GNT !== 2'b01) begin failures++; $display("FAIL mask_wr1_gnt: got %b want 01", GNT); end
        tick();
        drive(2'b01, 2'b01, 4'd2, 0, 32'h0, 0, 32'h0000_FFFF, 0);
        #3; model_eval();
        checks++;
        if (GNT !== 2'b01) begin failures++; $display("FAIL mask_wr2_gnt: got %b want 01", GNT); end
        tick();
        drive(2'b01, 2'b00, 4'd2, 0, 0, 0, 0, 0);
        #3; model_eval(); tick();
        drive(2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
        #3;
        checks++;
        if (RVALID !== 2'b01 || RDATA !== 32'hFFFF_0000) begin
            failures++;
            $display("FAIL mask_read: rvalid=%b rdata=%h want 01 ffff0000", RVALID, RDATA);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        for (int j = 0; j < 3; j++) begin
            drive(2'b10, 2'b10, 0, 4'(j), 0, $urandom, 0, 32'hFFFF_FFFF);
            #3; model_eval(); tick();
        end
        for (int j = 0; j < 4; j++) begin
            if (j < 3) drive(2'b10, 2'b00, 0, 4'(j), 0, 0, 0, 0);
            else       drive(2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
            #3;
            if (j > 0) begin
                checks++;
                if (RVALID !== 2'b10 || RDATA !== exp_rd) begin
                    failures++;
                    $display("FAIL b2b_rv[%0d]: rvalid=%b rdata=%h want 10 %h", j, RVALID, RDATA, exp_rd);
                end
            end
            model_eval();
            if (j < 3) begin
                checks++;
                if (GNT !== 2'b10) begin failures++; $display("FAIL b2b_gnt[%0d]: got %b want 10", j, GNT); end
            end
            tick();
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            drive(2'($urandom), 2'($urandom), 4'($urandom), 4'($urandom),
                  $urandom, $urandom, $urandom, $urandom);
            #3;
            checks++;
            if (RVALID !== exp_rv || (exp_rv != 0 && RDATA !== exp_rd)) begin
                failures++;
                $display("FAIL rand_rdata[%0d]: rvalid=%b rdata=%h want %b %h", i, RVALID, RDATA, exp_rv, exp_rd);
            end
            model_eval();
            checks++;
            if (GNT !== exp_gnt || RAM_CE !== (|exp_gnt)) begin
                failures++;
                $display("FAIL rand_gnt[%0d]: gnt=%b ce=%b want %b %b", i, GNT, RAM_CE, exp_gnt, |exp_gnt);
            end
            tick();
        end
        drive(2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
        #3; model_eval(); tick();
    endtask

    task automatic test_reset_midop();
        drive(2'b01, 2'b00, 4'd3, 0, 0, 0, 0, 0);
        #3; model_eval();
        checks++;
        if (GNT !== 2'b01) begin failures++; $display("FAIL midop_gnt: got %b want 01", GNT); end
        #2;
        RSTN = 1'b0;
        drive(2'b11, 2'b00, 4'd3, 4'd4, 0, 0, 0, 0);
        tick();
        model_reset();
        for (int j = 0; j < 2; j++) begin
            #3;
            checks++;
            if (RVALID !== 2'b00 || GNT !== 2'b00 || RAM_CE !== 1'b0) begin
                failures++;
                $display("FAIL midop_in_reset[%0d]: rvalid=%b gnt=%b ce=%b want 00 00 0", j, RVALID, GNT, RAM_CE);
            end
            tick();
        end
        RSTN = 1'b1;
        drive(2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
        #3;
        checks++;
        if (RVALID !== 2'b00) begin failures++; $display("FAIL midop_after_reset: rvalid=%b want 00", RVALID); end
`ifdef SP_RAM_ARBITER_INIT_EN
        checks++;
        if (RAM_CE !== 1'b1 || RAM_A !== 4'd0) begin
            failures++;
            $display("FAIL sweep_restart: ce=%b a=%0d want 1 0", RAM_CE, RAM_A);
        end
        for (int i = 0; i < 40 && INIT_DONE !== 1'b1; i++) tick();
        checks++;
        if (INIT_DONE !== 1'b1) begin failures++; $display("FAIL sweep_timeout: init_done=%b want 1", INIT_DONE); end
        model_run = 1;
        for (int i = 0; i < DEPTH; i++) sh[i] = '0;
`endif
        tick();
        drive(2'b11, 2'b00, 4'd1, 4'd2, 0, 0, 0, 0);
        #3; model_eval();
        checks++;
        if (GNT !== 2'b01) begin failures++; $display("FAIL ptr_after_reset: got %b want 01", GNT); end
        tick();
        drive(2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
        #3;
        checks++;
        if (RVALID !== 2'b01 || RDATA !== exp_rd) begin
            failures++;
            $display("FAIL post_reset_read: rvalid=%b rdata=%h want 01 %h", RVALID, RDATA, exp_rd);
        end
        tick();
    endtask

    initial begin
        RSTN = 1'b0;
        drive(2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
        exp_rd = '0; nxt_rd = '0;
        for (int i = 0; i < DEPTH; i++) sh[i] = '0;
        model_reset();
        test_reset();
        test_init();
        test_contention();
        test_fairness();
        test_masked_write();
        test_back_to_back();
        test_random();
        test_reset_midop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
